mc6845_crtc: RTL and testbench
==============================

# mc6845_crtc

Cathode-ray-tube controller in the style of the Motorola 6845, generating video timing and the refresh address for the display framestore. It sits on the CPU bus as a two-address peripheral: an address register plus eighteen internal registers. Timing advances one character per character-clock enable. Its outputs drive the memory address mux, the video ULA display enable, and the monitor sync lines.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `en` in 1: CPU bus strobe (PHI_2-qualified), one `clk` wide per bus cycle.
- `char_en` in 1: character-clock enable; timing counters advance only when high.
- `nCS` in 1: active-low chip select.
- `RnW` in 1: 1 = read, 0 = write.
- `RS` in 1: 0 = address register, 1 = data register.
- `data_bus` inout 8: CPU data. Driven only while `nCS`=0 and `RnW`=1, otherwise high-Z.
- `framestore_adr` out 14: refresh memory address (MA13..0).
- `cROWADDRESS` out 5: scan line within the character row (RA4..0).
- `display_en` out 1: active display area.
- `h_sync` out 1: horizontal sync, active high.
- `v_sync` out 1: vertical sync, active high.
- `cursor` out 1: cursor video, active high.

## Operation
- **Bus access.** A write occurs on a `clk` edge where `en`, `nCS`=0 and `RnW`=0.
  - RS=0 writes the 5-bit address register.
  - RS=1 writes the selected register.
  - R16/R17 and address values 18–31 ignore writes.
- **Registers and widths.**
  - R0 H total (8 bits); R1 H displayed (8); R2 H sync position (8).
  - R3 sync widths: [3:0] HSW, [7:4] VSW.
  - R4 V total (7); R5 V adjust (5); R6 V displayed (7); R7 V sync position (7).
  - R8 mode: stored only; non-interlaced operation always.
  - R9 max scan line (5).
  - R10 cursor start: [6:5] mode, [4:0] start line; R11 cursor end (5).
  - R12/R13 start address (6+8); R14/R15 cursor address (6+8).
- **Reads.** R14/R15 read back their values. R16/R17 read 0. All other registers, and the address register itself, read 0x00.
- **Horizontal counter `hc`.** Increments each `char_en`. When `hc`==R0 it wraps to 0 and ends the scan line.
- **Scan line counter `ra`.** Increments at each line end.
  - When `ra`==R9 at line end, it resets to 0 and the row counter `vc` increments.
  - During the adjust period, `ra` counts 0..R5-1.
- **Frame end.** Occurs at line end with `vc`==R4 and `ra`==R9.
  - If R5=0, the frame restarts immediately.
  - Otherwise an adjust period of R5 scan lines follows, then the frame restarts.
  - At restart `vc`=0 and `ra`=0.
- **Refresh address.**
  - At frame start, `ma` and `ma_row` load {R12,R13}.
  - Each `char_en`, `ma` increments.
  - At line end with `ra`==R9, `ma_row` ← `ma_row`+R1; otherwise `ma` reloads `ma_row`.
  - Arithmetic is modulo 2^14.
- **`display_en`** = (`hc`<R1) & (`vc`<R6) & not in adjust period.
- **`h_sync`.** Asserts when `hc`==R2 and stays high for HSW characters. HSW=0 means no horizontal sync.
- **`v_sync`.** Asserts at the start of the line where `vc`==R7 and `ra`==0, and stays high for VSW scan lines. VSW=0 means 16 scan lines.
- **`cursor`.** High when `ma`=={R14,R15}, `display_en`=1, and R10[4:0] ≤ `ra` ≤ R11. Gated further by the blink mode (see Configuration).

## Timing
- All outputs are registered and update on the `clk` edge where `char_en`=1.
- Register writes take effect on the next `char_en` tick.
- Reset clears all registers, counters, the address register and all outputs to 0, and releases `data_bus`.
- With all registers 0, each `char_en` is a complete one-character frame: `display_en`=0, `framestore_adr`=0.
- A bus write and a `char_en` tick in the same cycle: the counter step uses the old register value.
- Reset mid-frame restarts at `hc`=`vc`=`ra`=0.

## Configuration
- **Macro:** `MC6845_CURSOR_EN`.
- **Defined:**
  - Cursor logic and a field counter are present. The field counter counts `v_sync` rising edges.
  - R10[6:5] selects the mode: 00 steady, 01 off, 10 blink every 16 fields, 11 blink every 32 fields.
  - Blink duty is 50%.
- **Undefined:**
  - `cursor` is tied to 0.
  - R10/R11/R14/R15 remain writable, and R14/R15 remain readable.

## Test plan
- **Reset:** assert `RESET` → all outputs 0, `data_bus` high-Z, and a read of R14 returns 0x00.
- **Register access:** write addr=14 then 0x2A, addr=15 then 0x5C → reads return 0x2A and 0x5C. Addr=0 reads 0x00.
- **Horizontal timing:** R0=9, R1=6, R2=7, R3=0x22 → `h_sync` high for `hc`=7,8. `display_en` high for `hc`=0..5. Line period is 10 ticks.
- **Vertical timing:** R4=3, R5=2, R6=2, R7=3, R9=1, VSW=2 → frame of 4×2+2=10 scan lines. `v_sync` high on scan lines 6–7.
- **Address advance:** R12/R13=0x0100, R1=6 → `framestore_adr` runs 0x100..0x105 on row 0, both scan lines, then from 0x106 on row 1.
- **Cursor (macro on):** cursor address 0x0102, R10=0x00, R11=1 → `cursor` high at `hc`=2 on row 0, both scan lines. With R10=0x20, `cursor` stays 0.

Source files
------------

// File: rtl/mc6845_crtc.sv
// MC6845-style CRT controller: CPU register file, raster timing counters and refresh address.
// Optional cursor and blink logic is built when MC6845_CURSOR_EN is defined.
module mc6845_crtc (
    input  logic        clk,
    input  logic        RESET,
    input  logic        en,
    input  logic        char_en,
    input  logic        nCS,
    input  logic        RnW,
    input  logic        RS,
    inout  wire  [7:0]  data_bus,
    output logic [13:0] framestore_adr,
    output logic [4:0]  cROWADDRESS,
    output logic        display_en,
    output logic        h_sync,
    output logic        v_sync,
    output logic        cursor
);

    logic [4:0]  addr_reg;
    logic [7:0]  r0, r1, r2, r3, r8, r13, r15;
    logic [6:0]  r4, r6, r7, r10;
    logic [4:0]  r5, r9, r11;
    logic [5:0]  r12, r14;
    logic [7:0]  rd_data;

    logic [7:0]  hc;
    logic [4:0]  ra;
    logic [6:0]  vc;
    logic        in_adj;
    logic [13:0] ma, ma_row;
    logic [3:0]  hs_cnt;
    logic [4:0]  vs_cnt;

    logic        line_end, row_last, adj_last;
    logic [13:0] ma_next_row, start_adr;
    logic        disp_c;
    logic [4:0]  vsw_eff;
    logic        hs_start, hs_cont, vs_start, vs_cont, vs_go;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            addr_reg <= '0;
            r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0;
            r4 <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
            r8 <= '0; r9 <= '0; r10 <= '0; r11 <= '0;
            r12 <= '0; r13 <= '0; r14 <= '0; r15 <= '0;
        end else if (en && !nCS && !RnW) begin
            if (!RS) begin
                addr_reg <= data_bus[4:0];
            end else begin
                case (addr_reg)
                    5'd0:  r0  <= data_bus;
                    5'd1:  r1  <= data_bus;
                    5'd2:  r2  <= data_bus;
                    5'd3:  r3  <= data_bus;
                    5'd4:  r4  <= data_bus[6:0];
                    5'd5:  r5  <= data_bus[4:0];
                    5'd6:  r6  <= data_bus[6:0];
                    5'd7:  r7  <= data_bus[6:0];
                    5'd8:  r8  <= data_bus;
                    5'd9:  r9  <= data_bus[4:0];
                    5'd10: r10 <= data_bus[6:0];
                    5'd11: r11 <= data_bus[4:0];
                    5'd12: r12 <= data_bus[5:0];
                    5'd13: r13 <= data_bus;
                    5'd14: r14 <= data_bus[5:0];
                    5'd15: r15 <= data_bus;
                    default: ;
                endcase
            end
        end
    end

    // Only the cursor address is readable; everything else reads as zero.
    always_comb begin
        rd_data = 8'h00;
        if (RS) begin
            case (addr_reg)
                5'd14:   rd_data = {2'b00, r14};
                5'd15:   rd_data = r15;
                default: rd_data = 8'h00;
            endcase
        end
    end

    assign data_bus = (!nCS && RnW) ? rd_data : 8'bzzzz_zzzz;

    always_comb begin
        line_end    = (hc == r0);
        row_last    = (ra == r9);
        adj_last    = (({1'b0, ra} + 6'd1) >= {1'b0, r5});
        ma_next_row = ma_row + {6'b000000, r1};
        start_adr   = {r12, r13};
        disp_c      = (hc < r1) && (vc < r6) && !in_adj;
        vsw_eff     = (r3[7:4] == 4'd0) ? 5'd16 : {1'b0, r3[7:4]};
        hs_start    = (hc == r2) && (r3[3:0] != 4'd0);
        hs_cont     = h_sync && (hs_cnt != r3[3:0]);
        vs_start    = (vc == r7) && (ra == 5'd0) && !in_adj;
        vs_cont     = v_sync && (vs_cnt != vsw_eff);
        vs_go       = vs_start || vs_cont;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            hc     <= '0;
            ra     <= '0;
            vc     <= '0;
            in_adj <= 1'b0;
            ma     <= '0;
            ma_row <= '0;
        end else if (char_en) begin
            if (!line_end) begin
                hc <= hc + 8'd1;
                ma <= ma + 14'd1;
            end else begin
                hc <= 8'd0;
                if ((in_adj && adj_last) || (!in_adj && row_last && vc == r4 && r5 == 5'd0)) begin
                    vc     <= 7'd0;
                    ra     <= 5'd0;
                    in_adj <= 1'b0;
                    ma     <= start_adr;
                    ma_row <= start_adr;
                end else if (!in_adj && row_last) begin
                    // Row done: the next row starts R1 characters further on.
                    ra     <= 5'd0;
                    ma     <= ma_next_row;
                    ma_row <= ma_next_row;
                    if (vc == r4)
                        in_adj <= 1'b1;
                    else
                        vc <= vc + 7'd1;
                end else begin
                    ra <= ra + 5'd1;
                    ma <= ma_row;
                end
            end
        end
    end

    // Outputs present the counter state that was current at this tick.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            framestore_adr <= '0;
            cROWADDRESS    <= '0;
            display_en     <= 1'b0;
            h_sync         <= 1'b0;
            hs_cnt         <= '0;
            v_sync         <= 1'b0;
            vs_cnt         <= '0;
        end else if (char_en) begin
            framestore_adr <= ma;
            cROWADDRESS    <= ra;
            display_en     <= disp_c;
            h_sync         <= hs_start || hs_cont;
            hs_cnt         <= hs_start ? 4'd1 : (hs_cont ? hs_cnt + 4'd1 : 4'd0);
            if (hc == 8'd0) begin
                v_sync <= vs_go;
                vs_cnt <= vs_start ? 5'd1 : (vs_cont ? vs_cnt + 5'd1 : 5'd0);
            end
        end
    end

`ifdef MC6845_CURSOR_EN
    logic [4:0] field_cnt;
    logic       blink_ok;
    logic       cursor_c;

    always_comb begin
        case (r10[6:5])
            2'b00:   blink_ok = 1'b1;
            2'b01:   blink_ok = 1'b0;
            2'b10:   blink_ok = ~field_cnt[3];
            default: blink_ok = ~field_cnt[4];
        endcase
        cursor_c = (ma == {r14, r15}) && disp_c && (ra >= r10[4:0]) && (ra <= r11) && blink_ok;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            field_cnt <= '0;
            cursor    <= 1'b0;
        end else if (char_en) begin
            cursor <= cursor_c;
            if (hc == 8'd0 && vs_go && !v_sync)
                field_cnt <= field_cnt + 5'd1;
        end
    end

    wire unused_regs = &{1'b0, r8};
`else
    assign cursor = 1'b0;

    wire unused_regs = &{1'b0, r8, r10, r11};
`endif

endmodule

// File: tb/tb_mc6845_crtc.sv
// Self-checking bench for mc6845_crtc: register table, directed timing sequences and
// randomized configurations checked against a frame-arithmetic reference model.
module tb_mc6845_crtc;

    logic        clk = 1'b0;
    logic        RESET, en, char_en, nCS, RnW, RS;
    wire  [7:0]  data_bus;
    logic        tb_oe;
    logic [7:0]  tb_dout;
    logic [13:0] framestore_adr;
    logic [4:0]  cROWADDRESS;
    logic        display_en, h_sync, v_sync, cursor;

    assign data_bus = tb_oe ? tb_dout : 8'bzzzz_zzzz;

    mc6845_crtc dut (
        .clk(clk), .RESET(RESET), .en(en), .char_en(char_en),
        .nCS(nCS), .RnW(RnW), .RS(RS), .data_bus(data_bus),
        .framestore_adr(framestore_adr), .cROWADDRESS(cROWADDRESS),
        .display_en(display_en), .h_sync(h_sync), .v_sync(v_sync), .cursor(cursor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] adr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } reg_vec_t;

    int checks = 0;
    int errors = 0;
    int cfg [16];
    int log_adr [1024];
    int log_hs  [1024];
    int log_vs  [1024];
    int log_de  [1024];
    int log_cur [1024];

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] val, input logic with_tick);
        @(negedge clk);
        en = 1'b1; nCS = 1'b0; RnW = 1'b0; RS = rs;
        tb_oe = 1'b1; tb_dout = val; char_en = with_tick;
        @(posedge clk);
        #1;
        en = 1'b0; nCS = 1'b1; RnW = 1'b1; tb_oe = 1'b0; char_en = 1'b0;
    endtask

    task automatic set_reg(input int a, input int v);
        bus_write(1'b0, 8'(a), 1'b0);
        bus_write(1'b1, 8'(v), 1'b0);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] v);
        @(negedge clk);
        nCS = 1'b0; RnW = 1'b1; RS = rs;
        #2;
        v = data_bus;
        nCS = 1'b1;
    endtask

    task automatic tick;
        @(negedge clk);
        char_en = 1'b1;
        @(posedge clk);
        #1;
        char_en = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
    endtask

    // Position p counts character ticks since reset; the first frame starts at address 0.
    task automatic compute_expected(input int p, output int e_adr, output int e_ra,
                                    output int e_de, output int e_hs, output int e_vs,
                                    output int e_cur);
        int line_len, main_lines, total, frame_len, fidx, q, line, hcm;
        int row, sl, base, hsw, vsw_eff, lvs;
        bit adj;
        line_len   = cfg[0] + 1;
        main_lines = (cfg[4] + 1) * (cfg[9] + 1);
        total      = main_lines + cfg[5];
        frame_len  = line_len * total;
        fidx = p / frame_len;
        q    = p % frame_len;
        line = q / line_len;
        hcm  = q % line_len;
        adj  = (line >= main_lines);
        row  = adj ? cfg[4] + 1 : line / (cfg[9] + 1);
        sl   = adj ? line - main_lines : line % (cfg[9] + 1);
        base = (fidx == 0) ? 0 : cfg[12] * 256 + cfg[13];
        e_adr = (base + row * cfg[1] + hcm) % 16384;
        e_ra  = sl;
        e_de  = (!adj && hcm < cfg[1] && row < cfg[6]) ? 1 : 0;
        hsw   = cfg[3] % 16;
        e_hs  = (hsw != 0 && hcm >= cfg[2] && hcm < cfg[2] + hsw) ? 1 : 0;
        vsw_eff = cfg[3] / 16;
        if (vsw_eff == 0) vsw_eff = 16;
        lvs  = cfg[7] * (cfg[9] + 1);
        e_vs = (line >= lvs && line < lvs + vsw_eff) ? 1 : 0;
        e_cur = 0;
`ifdef MC6845_CURSOR_EN
        if ((cfg[10] / 32) % 4 == 0 && e_de == 1 && e_adr == cfg[14] * 256 + cfg[15] &&
            sl >= cfg[10] % 32 && sl <= cfg[11])
            e_cur = 1;
`endif
    endtask

    task automatic apply_stimulus;
        do_reset();
        for (int a = 0; a < 16; a++) set_reg(a, cfg[a]);
    endtask

    task automatic check_output(input int p);
        int e_adr, e_ra, e_de, e_hs, e_vs, e_cur;
        compute_expected(p, e_adr, e_ra, e_de, e_hs, e_vs, e_cur);
        check_val($sformatf("adr@%0d", p), int'(framestore_adr), e_adr);
        check_val($sformatf("ra@%0d", p), int'(cROWADDRESS), e_ra);
        check_val($sformatf("de@%0d", p), int'(display_en), e_de);
        check_val($sformatf("hs@%0d", p), int'(h_sync), e_hs);
        check_val($sformatf("vs@%0d", p), int'(v_sync), e_vs);
        check_val($sformatf("cur@%0d", p), int'(cursor), e_cur);
        if (p < 1024) begin
            log_adr[p] = int'(framestore_adr);
            log_hs[p]  = int'(h_sync);
            log_vs[p]  = int'(v_sync);
            log_de[p]  = int'(display_en);
            log_cur[p] = int'(cursor);
        end
    endtask

    task automatic run_frames(input int nticks);
        for (int n = 1; n <= nticks; n++) begin
            tick();
            check_output(n - 1);
        end
    endtask

    task automatic rand_cfg;
        int hmax, total, lvs, room, start, ca;
        cfg[0] = $urandom_range(15, 2);
        cfg[1] = $urandom_range(cfg[0] + 1, 0);
        cfg[2] = $urandom_range(cfg[0], 0);
        hmax   = cfg[0] + 1 - cfg[2];
        if (hmax > 15) hmax = 15;
        cfg[9] = $urandom_range(3, 0);
        cfg[4] = $urandom_range(4, 0);
        cfg[5] = $urandom_range(3, 0);
        cfg[6] = $urandom_range(cfg[4] + 1, 0);
        cfg[7] = $urandom_range(cfg[4], 0);
        total  = (cfg[4] + 1) * (cfg[9] + 1) + cfg[5];
        lvs    = cfg[7] * (cfg[9] + 1);
        room   = total - lvs;
        cfg[3] = ($urandom_range(room > 15 ? 15 : room, 1) * 16) + $urandom_range(hmax, 0);
        if (room >= 16 && $urandom_range(1, 0) == 1) cfg[3] = cfg[3] % 16;
        cfg[8]  = $urandom_range(255, 0);
        cfg[10] = $urandom_range(1, 0) * 32 + $urandom_range(3, 0);
        cfg[11] = $urandom_range(3, 0);
        cfg[12] = $urandom_range(63, 0);
        cfg[13] = $urandom_range(255, 0);
        start   = cfg[12] * 256 + cfg[13];
        ca      = (start + $urandom_range(40, 0)) % 16384;
        cfg[14] = ca / 256;
        cfg[15] = ca % 256;
    endtask

    task automatic plan_cfg;
        for (int a = 0; a < 16; a++) cfg[a] = 0;
        cfg[0] = 9;  cfg[1] = 6;  cfg[2] = 7;  cfg[3] = 8'h22;
        cfg[4] = 3;  cfg[5] = 2;  cfg[6] = 2;  cfg[7] = 3;  cfg[9] = 1;
        cfg[10] = 0; cfg[11] = 1; cfg[12] = 8'h01; cfg[13] = 8'h00;
        cfg[14] = 8'h01; cfg[15] = 8'h02;
    endtask

    initial begin
        reg_vec_t   vec [12];
        logic [7:0] rv;
        int         frame_len, nt;

        RESET = 1'b1; en = 1'b0; char_en = 1'b0; nCS = 1'b1; RnW = 1'b1; RS = 1'b0;
        tb_oe = 1'b0; tb_dout = 8'h00;
        repeat (2) @(negedge clk);
        RESET = 1'b0;

        // Reset clears registers and outputs.
        set_reg(14, 8'h2A);
        do_reset();
        check_val("rst_adr", int'(framestore_adr), 0);
        check_val("rst_ra", int'(cROWADDRESS), 0);
        check_val("rst_de", int'(display_en), 0);
        check_val("rst_hs", int'(h_sync), 0);
        check_val("rst_vs", int'(v_sync), 0);
        check_val("rst_cur", int'(cursor), 0);
        bus_write(1'b0, 8'd14, 1'b0);
        bus_read(1'b1, rv);
        check_val("rst_r14", int'(rv), 0);

        // Register access table.
        vec[0]  = '{5'd14, 8'h2A, 8'h2A};
        vec[1]  = '{5'd15, 8'h5C, 8'h5C};
        vec[2]  = '{5'd0,  8'h09, 8'h00};
        vec[3]  = '{5'd1,  8'h06, 8'h00};
        vec[4]  = '{5'd12, 8'h3F, 8'h00};
        vec[5]  = '{5'd14, 8'hFF, 8'h3F};
        vec[6]  = '{5'd15, 8'h81, 8'h81};
        vec[7]  = '{5'd16, 8'h55, 8'h00};
        vec[8]  = '{5'd17, 8'hAA, 8'h00};
        vec[9]  = '{5'd20, 8'h77, 8'h00};
        vec[10] = '{5'd10, 8'h60, 8'h00};
        vec[11] = '{5'd13, 8'h10, 8'h00};
        for (int i = 0; i < 12; i++) begin
            set_reg(int'(vec[i].adr), int'(vec[i].wdata));
            bus_read(1'b1, rv);
            check_val($sformatf("reg%0d", vec[i].adr), int'(rv), int'(vec[i].rdata));
        end
        bus_write(1'b0, 8'd14, 1'b0);
        bus_read(1'b1, rv);
        check_val("r14_keep", int'(rv), 8'h3F);
        bus_read(1'b0, rv);
        check_val("addr_read", int'(rv), 0);

        // All-zero registers: every tick is a one-character frame.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("zero_adr%0d", i), int'(framestore_adr), 0);
            check_val($sformatf("zero_de%0d", i), int'(display_en), 0);
            check_val($sformatf("zero_hs%0d", i), int'(h_sync), 0);
        end

        // A write to R0 in the same cycle as a tick: that tick still uses the old R0.
        do_reset();
        bus_write(1'b0, 8'd0, 1'b0);
        bus_write(1'b1, 8'd5, 1'b1);
        check_val("same_cyc0", int'(framestore_adr), 0);
        tick();
        check_val("same_cyc1", int'(framestore_adr), 0);
        tick();
        check_val("same_cyc2", int'(framestore_adr), 1);

        // Directed horizontal, vertical, address and cursor sequence.
        plan_cfg();
        apply_stimulus();
        run_frames(250);
        check_val("fr1_start", log_adr[100], 16'h100);
        check_val("row0_end", log_adr[105], 16'h105);
        check_val("row0_sl1", log_adr[110], 16'h100);
        check_val("row1_start", log_adr[120], 16'h106);
        check_val("fr2_start", log_adr[200], 16'h100);
        check_val("hs_106", log_hs[106], 0);
        check_val("hs_107", log_hs[107], 1);
        check_val("hs_108", log_hs[108], 1);
        check_val("hs_109", log_hs[109], 0);
        check_val("de_105", log_de[105], 1);
        check_val("de_106", log_de[106], 0);
        check_val("vs_159", log_vs[159], 0);
        check_val("vs_160", log_vs[160], 1);
        check_val("vs_179", log_vs[179], 1);
        check_val("vs_180", log_vs[180], 0);
`ifdef MC6845_CURSOR_EN
        check_val("cur_102", log_cur[102], 1);
        check_val("cur_112", log_cur[112], 1);
        check_val("cur_103", log_cur[103], 0);
`else
        check_val("cur_102", log_cur[102], 0);
`endif

        // Cursor mode 01 keeps the cursor off.
        plan_cfg();
        cfg[10] = 8'h20;
        apply_stimulus();
        run_frames(130);
        check_val("cur_off_102", log_cur[102], 0);

        // Reset part-way through a frame.
        plan_cfg();
        apply_stimulus();
        repeat (37) tick();
        do_reset();
        check_val("mid_rst_adr", int'(framestore_adr), 0);
        check_val("mid_rst_ra", int'(cROWADDRESS), 0);
        check_val("mid_rst_de", int'(display_en), 0);
        check_val("mid_rst_hs", int'(h_sync), 0);
        check_val("mid_rst_vs", int'(v_sync), 0);
        tick();
        check_val("mid_rst_tick", int'(framestore_adr), 0);

        // Randomized configurations against the reference model.
        for (int k = 0; k < 8; k++) begin
            rand_cfg();
            apply_stimulus();
            frame_len = (cfg[0] + 1) * ((cfg[4] + 1) * (cfg[9] + 1) + cfg[5]);
            nt = 2 * frame_len + 5;
            run_frames(nt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
